atm_pin_entry: RTL and testbench

Keypad front end for the ATM controller. Collects decimal digits from the keypad strobe interface while a card is present and accumulates them into a 16-bit binary PIN. It presents the PIN to the controller with a one-cycle `pin_stb`, then holds it stable until the controller requests a re-entry or the card is removed. It also rejects non-decimal keys, supports a clear key, and aborts a partial entry on inactivity timeout.

---
 rtl/atm_pkg.sv | 14 +
 rtl/atm_pin_entry_if.sv | 31 +++
 rtl/atm_timeout_counter.sv | 31 +++
 rtl/atm_pin_entry.sv | 142 ++++++++++++++
 tb/tb_atm_pin_entry.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// atm_pin_entry shared package: FSM state encoding and
// datapath constants used by the keypad front end.
package atm_pkg;

    localparam int PIN_W      = 16;
    localparam int DIGITO_MAX = 9;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        CAPTURA = 2'd1,
        LISTO   = 2'd2
    } estado_t;

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad/controller bundle for atm_pin_entry.
// master drives the keypad side, slave is the PIN collector.
interface atm_pin_entry_if;
    import atm_pkg::*;

    logic             tarjeta_recibida;
    logic             digito_stb;
    logic [3:0]       digito;
    logic             borrar;
    logic             reintentar;
    logic [PIN_W-1:0] pin;
    logic             pin_stb;
    logic [2:0]       cuenta_digitos;
    logic             digito_invalido;
    logic             tiempo_agotado;

    modport master (
        output tarjeta_recibida, digito_stb, digito,
        output borrar, reintentar,
        input  pin, pin_stb, cuenta_digitos,
        input  digito_invalido, tiempo_agotado
    );

    modport slave (
        input  tarjeta_recibida, digito_stb, digito,
        input  borrar, reintentar,
        output pin, pin_stb, cuenta_digitos,
        output digito_invalido, tiempo_agotado
    );

endinterface

// File: rtl/atm_timeout_counter.sv
// Idle-cycle counter for partial PIN entries; expiro flags
// the edge on which the count would reach the limit.
module atm_timeout_counter #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expiro
);

    localparam int W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [W-1:0] LIM = W'(TIMEOUT_CICLOS);

    logic [W-1:0] r_cnt;

    assign expiro = en && (r_cnt == LIM - 1'b1);

    // count idle cycles, clear wins, saturate at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad PIN collector: accumulates decimal digits into a
// binary PIN, strobes it when complete and holds it.
module atm_pin_entry
    import atm_pkg::*;
#(
    parameter int N_DIGITOS      = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic            clk,
    input logic            rst,
    atm_pin_entry_if.slave bus
);

    estado_t          r_estado;
    logic [PIN_W-1:0] r_pin;
    logic [2:0]       r_cuenta;
    logic             r_pin_stb;
    logic             r_invalido;
    logic             r_agotado;

    estado_t          w_estado_nx;
    logic [PIN_W-1:0] w_pin_nx;
    logic [2:0]       w_cuenta_nx;
    logic             w_pin_stb_nx;
    logic             w_invalido_nx;
    logic             w_agotado_nx;

    logic             w_t_clr;
    logic             w_t_en;
    logic             w_expiro;
    logic             w_dig_ok;
    logic [2:0]       w_cuenta_inc;
    logic [PIN_W-1:0] w_pin_acc;

    assign w_dig_ok     = bus.digito <= 4'(DIGITO_MAX);
    assign w_cuenta_inc = r_cuenta + 3'd1;
    assign w_pin_acc    = (r_pin << 3) + (r_pin << 1)
                        + {{(PIN_W-4){1'b0}}, bus.digito};

    // idle time only matters once a partial entry exists
    assign w_t_en = bus.tarjeta_recibida
                 && (r_estado == CAPTURA)
                 && (r_cuenta != 3'd0);

    atm_timeout_counter #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_t_clr),
        .en     (w_t_en),
        .expiro (w_expiro)
    );

    // next state, datapath and pulses; card loss overrides all
    always_comb begin
        w_estado_nx   = r_estado;
        w_pin_nx      = r_pin;
        w_cuenta_nx   = r_cuenta;
        w_pin_stb_nx  = 1'b0;
        w_invalido_nx = 1'b0;
        w_agotado_nx  = 1'b0;
        w_t_clr       = 1'b0;
        if (!bus.tarjeta_recibida) begin
            w_estado_nx = ESPERA;
            w_pin_nx    = '0;
            w_cuenta_nx = '0;
            w_t_clr     = 1'b1;
        end else begin
            unique case (r_estado)
                ESPERA: begin
                    w_estado_nx = CAPTURA;
                    w_t_clr     = 1'b1;
                end
                CAPTURA: begin
                    if (bus.borrar) begin
                        w_pin_nx    = '0;
                        w_cuenta_nx = '0;
                        w_t_clr     = 1'b1;
                    end else if (w_expiro) begin
                        w_agotado_nx = 1'b1;
                        w_pin_nx     = '0;
                        w_cuenta_nx  = '0;
                        w_t_clr      = 1'b1;
                    end else if (bus.digito_stb) begin
                        if (w_dig_ok) begin
                            w_pin_nx    = w_pin_acc;
                            w_cuenta_nx = w_cuenta_inc;
                            w_t_clr     = 1'b1;
                            if (w_cuenta_inc == 3'(N_DIGITOS)) begin
                                w_pin_stb_nx = 1'b1;
                                w_estado_nx  = LISTO;
                            end
                        end else begin
                            w_invalido_nx = 1'b1;
                        end
                    end
                end
                LISTO: begin
                    w_t_clr = 1'b1;
                    if (bus.reintentar) begin
                        w_pin_nx    = '0;
                        w_cuenta_nx = '0;
                        w_estado_nx = CAPTURA;
                    end
                end
                default: begin
                    w_estado_nx = ESPERA;
                    w_pin_nx    = '0;
                    w_cuenta_nx = '0;
                    w_t_clr     = 1'b1;
                end
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado   <= ESPERA;
            r_pin      <= '0;
            r_cuenta   <= '0;
            r_pin_stb  <= 1'b0;
            r_invalido <= 1'b0;
            r_agotado  <= 1'b0;
        end else begin
            r_estado   <= w_estado_nx;
            r_pin      <= w_pin_nx;
            r_cuenta   <= w_cuenta_nx;
            r_pin_stb  <= w_pin_stb_nx;
            r_invalido <= w_invalido_nx;
            r_agotado  <= w_agotado_nx;
        end
    end

    assign bus.pin             = r_pin;
    assign bus.pin_stb         = r_pin_stb;
    assign bus.cuenta_digitos  = r_cuenta;
    assign bus.digito_invalido = r_invalido;
    assign bus.tiempo_agotado  = r_agotado;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: directed scenarios plus random
// traffic against a digit-queue reference model.
module tb_atm_pin_entry;
    import atm_pkg::*;

    localparam int N = 4;
    localparam int T = 5;

    logic clk = 1'b0;
    logic rst;

    atm_pin_entry_if bus();

    atm_pin_entry #(
        .N_DIGITOS      (N),
        .TIMEOUT_CICLOS (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: session flag, complete flag, digit queue
    bit m_act;
    bit m_done;
    int q[$];
    int m_idle;
    bit e_stb, e_inv, e_to;

    function automatic int m_pin();
        int p = 0;
        foreach (q[i]) p = p * 10 + q[i];
        return p;
    endfunction

    function automatic void m_reset();
        m_act  = 1'b0;
        m_done = 1'b0;
        q.delete();
        m_idle = 0;
        e_stb  = 1'b0;
        e_inv  = 1'b0;
        e_to   = 1'b0;
    endfunction

    function automatic void m_step(bit card, bit stb, int d,
                                   bit clr, bit rty);
        e_stb = 1'b0;
        e_inv = 1'b0;
        e_to  = 1'b0;
        if (!card) begin
            m_reset();
        end else if (!m_act) begin
            m_act = 1'b1;
        end else if (m_done) begin
            if (rty) begin
                m_done = 1'b0;
                q.delete();
                m_idle = 0;
            end
        end else if (clr) begin
            q.delete();
            m_idle = 0;
        end else if (q.size() > 0 && m_idle + 1 == T) begin
            e_to = 1'b1;
            q.delete();
            m_idle = 0;
        end else if (stb && d > DIGITO_MAX) begin
            e_inv = 1'b1;
            if (q.size() > 0) m_idle++;
        end else if (stb) begin
            q.push_back(d);
            m_idle = 0;
            if (q.size() == N) begin
                e_stb  = 1'b1;
                m_done = 1'b1;
            end
        end else if (q.size() > 0) begin
            m_idle++;
        end
    endfunction

    task automatic cyc(bit stb, int d, bit clr, bit rty);
        bus.digito_stb = stb;
        bus.digito     = 4'(d);
        bus.borrar     = clr;
        bus.reintentar = rty;
        @(posedge clk);
        #1;
        m_step(bus.tarjeta_recibida, stb, d, clr, rty);
        bus.digito_stb = 1'b0;
        bus.borrar     = 1'b0;
        bus.reintentar = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic new_session();
        bus.tarjeta_recibida = 1'b0;
        cyc(0, 0, 0, 0);
        bus.tarjeta_recibida = 1'b1;
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.tarjeta_recibida = 1'b0;
        bus.digito_stb       = 1'b0;
        bus.digito           = 4'd0;
        bus.borrar           = 1'b0;
        bus.reintentar       = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        total++;
        if (bus.pin !== 16'd0) begin
            bad++;
            $display("FAIL reset_pin got=%0d exp=0", bus.pin);
        end
        total++;
        if (bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0",
                     bus.cuenta_digitos);
        end
        total++;
        if ({bus.pin_stb, bus.digito_invalido,
             bus.tiempo_agotado} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses got=%b exp=000",
                     {bus.pin_stb, bus.digito_invalido,
                      bus.tiempo_agotado});
        end
    endtask

    task automatic test_basic();
        int dig[4] = '{4, 7, 2, 1};
        int nstb = 0;
        new_session();
        for (int i = 0; i < 4; i++) begin
            cyc(1, dig[i], 0, 0);
            nstb += int'(bus.pin_stb);
            total++;
            if (bus.cuenta_digitos !== 3'(i + 1)) begin
                bad++;
                $display("FAIL basic_cnt got=%0d exp=%0d",
                         bus.cuenta_digitos, i + 1);
            end
        end
        total++;
        if (bus.pin !== 16'd4721 || bus.pin_stb !== 1'b1) begin
            bad++;
            $display("FAIL basic_pin got=%0d stb=%b exp=4721 stb=1",
                     bus.pin, bus.pin_stb);
        end
        cyc(0, 0, 0, 0);
        nstb += int'(bus.pin_stb);
        total++;
        if (nstb != 1) begin
            bad++;
            $display("FAIL basic_stb_count got=%0d exp=1", nstb);
        end
    endtask

    task automatic test_invalid();
        int dig[5] = '{4, 12, 7, 2, 1};
        int ninv = 0;
        new_session();
        for (int i = 0; i < 5; i++) begin
            cyc(1, dig[i], 0, 0);
            ninv += int'(bus.digito_invalido);
            if (i == 1) begin
                total++;
                if (bus.digito_invalido !== 1'b1 ||
                    bus.cuenta_digitos !== 3'd1) begin
                    bad++;
                    $display("FAIL inv_pulse got=%b cnt=%0d exp=1 cnt=1",
                             bus.digito_invalido, bus.cuenta_digitos);
                end
            end
        end
        total++;
        if (bus.pin !== 16'd4721 || ninv != 1) begin
            bad++;
            $display("FAIL inv_final got=%0d n=%0d exp=4721 n=1",
                     bus.pin, ninv);
        end
    endtask

    task automatic test_clear();
        int dig[4] = '{1, 2, 3, 4};
        new_session();
        cyc(1, 9, 0, 0);
        cyc(1, 9, 0, 0);
        cyc(0, 0, 1, 0);
        total++;
        if (bus.pin !== 16'd0 || bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL clear got=%0d cnt=%0d exp=0 cnt=0",
                     bus.pin, bus.cuenta_digitos);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, dig[i], 0, 0);
            total++;
            if (bus.pin_stb !== (i == 3)) begin
                bad++;
                $display("FAIL clear_stb digit=%0d got=%b exp=%b",
                         i, bus.pin_stb, i == 3);
            end
        end
        total++;
        if (bus.pin !== 16'd1234) begin
            bad++;
            $display("FAIL clear_pin got=%0d exp=1234", bus.pin);
        end
    endtask

    task automatic test_timeout();
        int dig[4] = '{0, 0, 0, 7};
        new_session();
        cyc(1, 3, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0);
            total++;
            if (bus.tiempo_agotado !== (i == 5)) begin
                bad++;
                $display("FAIL to_pulse idle=%0d got=%b exp=%b",
                         i, bus.tiempo_agotado, i == 5);
            end
        end
        total++;
        if (bus.pin !== 16'd0 || bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL to_clear got=%0d cnt=%0d exp=0 cnt=0",
                     bus.pin, bus.cuenta_digitos);
        end
        for (int i = 0; i < 4; i++) cyc(1, dig[i], 0, 0);
        total++;
        if (bus.pin !== 16'd7 || bus.pin_stb !== 1'b1) begin
            bad++;
            $display("FAIL to_after got=%0d stb=%b exp=7 stb=1",
                     bus.pin, bus.pin_stb);
        end
        new_session();
        cyc(1, 5, 0, 0);
        idle(4);
        cyc(1, 6, 0, 0);
        total++;
        if (bus.tiempo_agotado !== 1'b1 ||
            bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL to_vs_digit got=%b cnt=%0d exp=1 cnt=0",
                     bus.tiempo_agotado, bus.cuenta_digitos);
        end
    endtask

    task automatic test_hold_retry();
        int dig[4] = '{4, 7, 2, 1};
        new_session();
        for (int i = 0; i < 4; i++) cyc(1, dig[i], 0, 0);
        cyc(1, 5, 0, 0);
        cyc(1, 11, 0, 0);
        total++;
        if (bus.digito_invalido !== 1'b0) begin
            bad++;
            $display("FAIL hold_inv got=%b exp=0", bus.digito_invalido);
        end
        cyc(0, 0, 1, 0);
        idle(8);
        total++;
        if (bus.pin !== 16'd4721 || bus.cuenta_digitos !== 3'd4) begin
            bad++;
            $display("FAIL hold got=%0d cnt=%0d exp=4721 cnt=4",
                     bus.pin, bus.cuenta_digitos);
        end
        cyc(0, 0, 0, 1);
        total++;
        if (bus.pin !== 16'd0 || bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL retry_clear got=%0d cnt=%0d exp=0 cnt=0",
                     bus.pin, bus.cuenta_digitos);
        end
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        total++;
        if (bus.pin !== 16'd1111 || bus.pin_stb !== 1'b1) begin
            bad++;
            $display("FAIL retry_pin got=%0d stb=%b exp=1111 stb=1",
                     bus.pin, bus.pin_stb);
        end
    endtask

    task automatic test_card_drop();
        new_session();
        cyc(1, 1, 0, 0);
        cyc(1, 2, 0, 0);
        bus.tarjeta_recibida = 1'b0;
        cyc(1, 3, 0, 0);
        total++;
        if (bus.pin !== 16'd0 || bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL drop got=%0d cnt=%0d exp=0 cnt=0",
                     bus.pin, bus.cuenta_digitos);
        end
        bus.tarjeta_recibida = 1'b1;
        cyc(1, 5, 0, 0);
        total++;
        if (bus.cuenta_digitos !== 3'd0) begin
            bad++;
            $display("FAIL rise_ignore got=%0d exp=0",
                     bus.cuenta_digitos);
        end
        cyc(1, 5, 0, 0);
        total++;
        if (bus.cuenta_digitos !== 3'd1 || bus.pin !== 16'd5) begin
            bad++;
            $display("FAIL rise_next got=%0d cnt=%0d exp=5 cnt=1",
                     bus.pin, bus.cuenta_digitos);
        end
    endtask

    task automatic test_async_reset();
        new_session();
        cyc(1, 8, 0, 0);
        cyc(1, 6, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.pin !== 16'd0 || bus.cuenta_digitos !== 3'd0 ||
            {bus.pin_stb, bus.digito_invalido,
             bus.tiempo_agotado} !== 3'b000) begin
            bad++;
            $display("FAIL async_rst got=%0d cnt=%0d exp=0 cnt=0",
                     bus.pin, bus.cuenta_digitos);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_random();
        bit stb, clr, rty;
        int d;
        bus.tarjeta_recibida = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (!bus.tarjeta_recibida)
                bus.tarjeta_recibida = $urandom_range(0, 1) == 0;
            else if ($urandom_range(0, 99) < 2)
                bus.tarjeta_recibida = 1'b0;
            stb = $urandom_range(0, 99) < 40;
            d   = $urandom_range(0, 15);
            clr = $urandom_range(0, 99) < 3;
            rty = $urandom_range(0, 99) < 6;
            cyc(stb, d, clr, rty);
            total++;
            if (bus.pin !== 16'(m_pin()) ||
                bus.cuenta_digitos !== 3'(q.size())) begin
                bad++;
                $display("FAIL rnd_pin n=%0d got=%0d/%0d exp=%0d/%0d",
                         n, bus.pin, bus.cuenta_digitos,
                         m_pin(), q.size());
            end
            total++;
            if ({bus.pin_stb, bus.digito_invalido,
                 bus.tiempo_agotado} !== {e_stb, e_inv, e_to}) begin
                bad++;
                $display("FAIL rnd_pulses n=%0d got=%b exp=%b", n,
                         {bus.pin_stb, bus.digito_invalido,
                          bus.tiempo_agotado},
                         {e_stb, e_inv, e_to});
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_basic();
        test_invalid();
        test_clear();
        test_timeout();
        test_hold_retry();
        test_card_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
